ahblite_slave_mux: RTL and testbench
====================================

Name: ahblite_slave_mux

Overview:
AHB-Lite data-phase return path that sits directly downstream of the system address decoder. It latches the decoder's per-port HSEL lines during the address phase. During the following data phase it routes the selected slave's HRDATA, HREADYOUT and HRESP back to the Cortex-M0 master. It contains a built-in default slave that returns the two-cycle AHB ERROR response for active transfers that hit no enabled port, and it keeps a saturating count of those errors.

Parameters:
PORT0_EN, 1, enable for port 0 (RAMCODE, 0x0000_0000-0x0000_FFFF); 0 means HSEL0 is ignored.
PORT1_EN, 1, enable for port 1 (RAMDATA, 0x2000_0000-0x2000_FFFF).
PORT2_EN, 1, enable for port 2 (WaterLight, 0x4000_0000-0x4000_000F).
PORT3_EN, 1, enable for port 3 (UART, 0x4000_0010-0x4000_001F).
ERR_CNT_W, 8, width of the error counter.

Ports:
HCLK  in  1  system clock; all state updates on rising edge
HRESETn  in  1  synchronous active-low reset
HREADY  in  1  global bus HREADY (this block's HREADYOUT fed back by the top level)
HTRANS  in  2  master transfer type; only bit 1 (NONSEQ/SEQ) is used
P0_HSEL..P3_HSEL  in  1 each  decoder select lines (address phase)
P0_HREADYOUT..P3_HREADYOUT  in  1 each  slave ready outputs
P0_HRESP..P3_HRESP  in  1 each  slave responses (0 OKAY, 1 ERROR)
P0_HRDATA..P3_HRDATA  in  32 each  slave read data
HREADYOUT  out  1  muxed ready to master
HRESP  out  1  muxed response to master
HRDATA  out  32  muxed read data to master
MULTI_SEL  out  1  one-cycle pulse when more than one enabled HSEL is high while HREADY=1
ERR_CNT  out  ERR_CNT_W  saturating count of default-slave ERROR responses

Behaviour:
- Reset (HRESETn=0 at a rising edge):
  - sel_q=4'b0, FSM=IDLE, ERR_CNT=0, MULTI_SEL=0.
  - Outputs then read HREADYOUT=1, HRESP=0, HRDATA=0.
- Reset overrides everything, including an in-flight error: reset asserted in ERR1 gives IDLE and HREADYOUT=1 on the next edge.
- Address-phase capture happens only on edges where HREADY=1:
  - en_sel = {P3_HSEL&PORT3_EN, ..., P0_HSEL&PORT0_EN}.
  - If HTRANS[1]=1: sel_q <= en_sel reduced to one-hot with fixed priority P0>P1>P2>P3.
  - If HTRANS[1]=0: sel_q <= 0 (IDLE/BUSY gets zero-wait OKAY).
  - MULTI_SEL <= HTRANS[1] & (popcount(en_sel)>1). It is 0 on every other edge.
- When HREADY=0, sel_q holds, so the data phase stays bound to the slave latched at its address phase.
- Data-phase output mux (combinational from sel_q and FSM):
  - sel_q has bit n set: HREADYOUT=Pn_HREADYOUT, HRESP=Pn_HRESP, HRDATA=Pn_HRDATA.
  - sel_q=0 and FSM=IDLE: HREADYOUT=1, HRESP=0, HRDATA=0.
  - FSM=ERR1: HREADYOUT=0, HRESP=1, HRDATA=0.
  - FSM=ERR2: HREADYOUT=1, HRESP=1, HRDATA=0.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE -> ERR1 on an HREADY=1 edge with HTRANS[1]=1 and en_sel=0.
  - ERR1 -> ERR2 unconditionally, one cycle later.
  - ERR2 -> ERR1 if an edge with HREADY=1, HTRANS[1]=1 and en_sel=0 occurs (back-to-back unmapped).
  - ERR2 -> IDLE otherwise, with sel_q capturing any mapped transfer as normal.
  - The ERROR response is therefore exactly 2 cycles: not-ready then ready, HRESP high in both.
- ERR_CNT increments by 1 on each ERR1 entry and saturates at all-ones (no wrap).
- A disabled port's HSEL is treated as absent, so a transfer to that port receives the ERROR response.
- Wait states from a selected slave are passed straight through; latency added by this block is zero cycles.

Test Plan:
- Reset, then a NONSEQ read with P1_HSEL=1 and P1_HRDATA=32'hDEADBEEF -> next cycle HRDATA=32'hDEADBEEF, HREADYOUT=1, HRESP=0. ERR_CNT=0.
- NONSEQ to P3 with P3_HREADYOUT held low 3 cycles -> HREADYOUT low exactly 3 cycles, sel_q stable throughout; the P0 select presented in the same stall is ignored until HREADY=1.
- NONSEQ with all HSEL=0 (address 0x3000_0000) -> cycle 1: HREADYOUT=0, HRESP=1. Cycle 2: HREADYOUT=1, HRESP=1. Then IDLE. ERR_CNT=1.
- Two back-to-back unmapped NONSEQ, then a P0 access -> two ERR1/ERR2 pairs with no IDLE between, ERR_CNT=2, then P0 data returned OKAY.
- P0_HSEL=P2_HSEL=1 on NONSEQ -> MULTI_SEL pulses for 1 cycle and P0 data is returned. With PORT2_EN=0 and only P2_HSEL=1 -> ERROR response.
- Assert HRESETn=0 while FSM=ERR1 -> next edge HREADYOUT=1, HRESP=0, ERR_CNT=0. Drive 300 unmapped transfers -> ERR_CNT saturates at 8'hFF.

Source files
------------

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite data-phase return mux with a built-in default slave.
// The block records which slave owns the next data phase while the address
// phase is accepted, then steers that slave's HRDATA/HREADYOUT/HRESP back to
// the master. When an active transfer hits no enabled port, it produces the
// two-cycle ERROR response and counts the event in a saturating counter.
module ahblite_slave_mux #(
    parameter bit          PORT0_EN  = 1'b1,  // RAMCODE    0x0000_0000-0x0000_FFFF
    parameter bit          PORT1_EN  = 1'b1,  // RAMDATA    0x2000_0000-0x2000_FFFF
    parameter bit          PORT2_EN  = 1'b1,  // WaterLight 0x4000_0000-0x4000_000F
    parameter bit          PORT3_EN  = 1'b1,  // UART       0x4000_0010-0x4000_001F
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 HREADY,
    input  logic [1:0]           HTRANS,

    input  logic                 P0_HSEL,
    input  logic                 P1_HSEL,
    input  logic                 P2_HSEL,
    input  logic                 P3_HSEL,

    input  logic                 P0_HREADYOUT,
    input  logic                 P1_HREADYOUT,
    input  logic                 P2_HREADYOUT,
    input  logic                 P3_HREADYOUT,

    input  logic                 P0_HRESP,
    input  logic                 P1_HRESP,
    input  logic                 P2_HRESP,
    input  logic                 P3_HRESP,

    input  logic [31:0]          P0_HRDATA,
    input  logic [31:0]          P1_HRDATA,
    input  logic [31:0]          P2_HRDATA,
    input  logic [31:0]          P3_HRDATA,

    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [31:0]          HRDATA,
    output logic                 MULTI_SEL,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    // Default-slave states: ERR1 is the not-ready half of the ERROR
    // response, ERR2 the ready half.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    // Fixed-priority reduction to one-hot: port 0 wins over port 1, and so on.
    function automatic logic [3:0] first_sel(input logic [3:0] sel);
        logic [3:0] result;
        result = 4'b0000;
        if (sel[0])      result = 4'b0001;
        else if (sel[1]) result = 4'b0010;
        else if (sel[2]) result = 4'b0100;
        else if (sel[3]) result = 4'b1000;
        return result;
    endfunction

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    logic [3:0] en_sel;       // selects from enabled ports only
    logic       addr_valid;   // an active transfer is accepted on this edge
    logic       unmapped;     // active transfer that no enabled port claims
    logic       multi_hit;    // more than one enabled port claims it

    // A disabled port's HSEL is masked here, so a transfer aimed at it
    // looks unmapped and falls through to the default slave.
    assign en_sel     = {P3_HSEL & PORT3_EN, P2_HSEL & PORT2_EN,
                         P1_HSEL & PORT1_EN, P0_HSEL & PORT0_EN};
    assign addr_valid = HREADY & HTRANS[1];
    assign unmapped   = addr_valid & (en_sel == 4'b0000);
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_hit  = addr_valid & (|(en_sel & (en_sel - 4'd1)));

    // HTRANS[0] only distinguishes IDLE/BUSY or NONSEQ/SEQ, which this
    // block treats identically.
    logic unused_htrans0;
    assign unused_htrans0 = HTRANS[0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic [3:0]           sel_q,     sel_d;
    state_t               state_q,   state_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 multi_q,   multi_d;
    logic                 err_entry;

    // Data-phase owner: captured only when the bus accepts an address, held
    // through wait states so the data phase stays bound to its slave.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first;
        // a path that leaves it unassigned would infer a latch.
        sel_d = sel_q;
        if (HREADY) begin
            sel_d = HTRANS[1] ? first_sel(en_sel) : 4'b0000;
        end
    end

    // Default-slave sequencing: IDLE -> ERR1 -> ERR2 -> (ERR1 | IDLE).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (unmapped) state_d = ST_ERR1;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = unmapped ? ST_ERR1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Error counter and multi-select flag: the counter bumps on every ERR1
    // entry and sticks at all-ones; the flag is a one-edge pulse.
    always_comb begin
        err_entry = (state_d == ST_ERR1) && (state_q != ST_ERR1);
        err_cnt_d = err_cnt_q;
        if (err_entry && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
        multi_d = multi_hit;
    end

    // ------------------------------------------------------------------
    // State registers (synchronous active-low reset)
    // ------------------------------------------------------------------
    // Reset has priority over everything, including an ERROR in flight.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            sel_q     <= 4'b0000;
            state_q   <= ST_IDLE;
            err_cnt_q <= '0;
            multi_q   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // register samples the pre-edge values of its neighbours.
            sel_q     <= sel_d;
            state_q   <= state_d;
            err_cnt_q <= err_cnt_d;
            multi_q   <= multi_d;
        end
    end

    assign ERR_CNT   = err_cnt_q;
    assign MULTI_SEL = multi_q;

    // ------------------------------------------------------------------
    // Data-phase return mux
    // ------------------------------------------------------------------
    // The default slave's response takes precedence; otherwise the latched
    // one-hot owner is passed straight through, adding no latency. With no
    // owner the bus sees a zero-wait OKAY.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = 32'h0000_0000;
        unique case (state_q)
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: begin
                HREADYOUT = 1'b1;
                HRESP     = 1'b1;
            end
            default: begin
                if (sel_q[0]) begin
                    HREADYOUT = P0_HREADYOUT;
                    HRESP     = P0_HRESP;
                    HRDATA    = P0_HRDATA;
                end else if (sel_q[1]) begin
                    HREADYOUT = P1_HREADYOUT;
                    HRESP     = P1_HRESP;
                    HRDATA    = P1_HRDATA;
                end else if (sel_q[2]) begin
                    HREADYOUT = P2_HREADYOUT;
                    HRESP     = P2_HRESP;
                    HRDATA    = P2_HRDATA;
                end else if (sel_q[3]) begin
                    HREADYOUT = P3_HREADYOUT;
                    HRESP     = P3_HRESP;
                    HRDATA    = P3_HRDATA;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Testbench for ahblite_slave_mux: a table of per-cycle records drives the
// main scenarios through a scoreboard queue, and short hand-written sequences
// cover the disabled-port, reset-in-error and counter-saturation cases.
module tb_ahblite_slave_mux;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'hDEADBEEF;
    localparam logic [31:0] D2 = 32'h2222_2222;
    localparam logic [31:0] D3 = 32'h3333_3333;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [1:0]  HTRANS = 2'b00;
    logic [3:0]  hsel = 4'h0;
    logic [3:0]  prdy = 4'hF;
    logic [3:0]  presp = 4'h0;

    // Instance A: all ports enabled.
    logic        hready_a, hreadyout_a, hresp_a, multi_a;
    logic [31:0] hrdata_a;
    logic [7:0]  cnt_a;
    // Instance B: port 2 disabled.
    logic        hready_b, hreadyout_b, hresp_b, multi_b;
    logic [31:0] hrdata_b;
    logic [7:0]  cnt_b;

    // The top level feeds each mux's HREADYOUT back as the bus HREADY.
    assign hready_a = hreadyout_a;
    assign hready_b = hreadyout_b;

    always #5 HCLK = ~HCLK;

    ahblite_slave_mux dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HREADY(hready_a), .HTRANS(HTRANS),
        .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]),
        .P0_HREADYOUT(prdy[0]), .P1_HREADYOUT(prdy[1]),
        .P2_HREADYOUT(prdy[2]), .P3_HREADYOUT(prdy[3]),
        .P0_HRESP(presp[0]), .P1_HRESP(presp[1]), .P2_HRESP(presp[2]), .P3_HRESP(presp[3]),
        .P0_HRDATA(D0), .P1_HRDATA(D1), .P2_HRDATA(D2), .P3_HRDATA(D3),
        .HREADYOUT(hreadyout_a), .HRESP(hresp_a), .HRDATA(hrdata_a),
        .MULTI_SEL(multi_a), .ERR_CNT(cnt_a)
    );

    ahblite_slave_mux #(.PORT2_EN(1'b0)) dut_p2off (
        .HCLK(HCLK), .HRESETn(HRESETn), .HREADY(hready_b), .HTRANS(HTRANS),
        .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]),
        .P0_HREADYOUT(prdy[0]), .P1_HREADYOUT(prdy[1]),
        .P2_HREADYOUT(prdy[2]), .P3_HREADYOUT(prdy[3]),
        .P0_HRESP(presp[0]), .P1_HRESP(presp[1]), .P2_HRESP(presp[2]), .P3_HRESP(presp[3]),
        .P0_HRDATA(D0), .P1_HRDATA(D1), .P2_HRDATA(D2), .P3_HRDATA(D3),
        .HREADYOUT(hreadyout_b), .HRESP(hresp_b), .HRDATA(hrdata_b),
        .MULTI_SEL(multi_b), .ERR_CNT(cnt_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One record = inputs presented for one cycle plus the outputs expected
    // during that cycle (data phase of the previously accepted address).
    typedef struct {
        string       name;
        logic        trans;
        logic [3:0]  hsel;
        logic [3:0]  rdy;
        logic [3:0]  resp;
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_data;
        logic        e_multi;
        logic [7:0]  e_cnt;
    } vec_t;

    typedef struct {
        string       name;
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_data;
        logic        e_multi;
        logic [7:0]  e_cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    function automatic vec_t mk(input string name, input logic trans, input logic [3:0] hs,
                                input logic [3:0] rdy, input logic [3:0] resp,
                                input logic e_rdy, input logic e_resp, input logic [31:0] e_data,
                                input logic e_multi, input logic [7:0] e_cnt);
        vec_t v;
        v.name = name; v.trans = trans; v.hsel = hs; v.rdy = rdy; v.resp = resp;
        v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_data = e_data;
        v.e_multi = e_multi; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic apply(input logic trans, input logic [3:0] hs,
                         input logic [3:0] rdy, input logic [3:0] resp);
        HTRANS = {trans, 1'b0};
        hsel   = hs;
        prdy   = rdy;
        presp  = resp;
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESETn = 1'b0;
        apply(1'b0, 4'h0, 4'hF, 4'h0);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    task automatic check_a(input string name, input logic rdy, input logic resp,
                           input logic [31:0] data, input logic [7:0] cnt);
        check({name, ".a_hreadyout"}, 32'(hreadyout_a), 32'(rdy));
        check({name, ".a_hresp"},     32'(hresp_a),     32'(resp));
        check({name, ".a_hrdata"},    hrdata_a,         data);
        check({name, ".a_err_cnt"},   32'(cnt_a),       32'(cnt));
    endtask

    task automatic check_b(input string name, input logic rdy, input logic resp,
                           input logic [31:0] data, input logic [7:0] cnt);
        check({name, ".b_hreadyout"}, 32'(hreadyout_b), 32'(rdy));
        check({name, ".b_hresp"},     32'(hresp_b),     32'(resp));
        check({name, ".b_hrdata"},    hrdata_b,         data);
        check({name, ".b_err_cnt"},   32'(cnt_b),       32'(cnt));
    endtask

    initial begin
        //             name              tr  hsel     rdy      resp     rdy resp data  mul cnt
        vecs.push_back(mk("p1_addr",     1, 4'b0010, 4'hF,    4'h0,    1, 0, 32'h0, 0, 8'd0));
        vecs.push_back(mk("p1_data",     0, 4'b0000, 4'hF,    4'h0,    1, 0, D1,    0, 8'd0));
        vecs.push_back(mk("p3_addr",     1, 4'b1000, 4'hF,    4'h0,    1, 0, 32'h0, 0, 8'd0));
        vecs.push_back(mk("p3_wait1",    1, 4'b0001, 4'b0111, 4'h0,    0, 0, D3,    0, 8'd0));
        vecs.push_back(mk("p3_wait2",    1, 4'b0001, 4'b0111, 4'h0,    0, 0, D3,    0, 8'd0));
        vecs.push_back(mk("p3_wait3",    1, 4'b0001, 4'b0111, 4'h0,    0, 0, D3,    0, 8'd0));
        vecs.push_back(mk("p3_done",     1, 4'b0001, 4'hF,    4'h0,    1, 0, D3,    0, 8'd0));
        vecs.push_back(mk("p0_data",     0, 4'b0000, 4'hF,    4'h0,    1, 0, D0,    0, 8'd0));
        vecs.push_back(mk("unmap_addr",  1, 4'b0000, 4'hF,    4'h0,    1, 0, 32'h0, 0, 8'd0));
        vecs.push_back(mk("unmap_err1",  0, 4'b0000, 4'hF,    4'h0,    0, 1, 32'h0, 0, 8'd1));
        vecs.push_back(mk("unmap_err2",  0, 4'b0000, 4'hF,    4'h0,    1, 1, 32'h0, 0, 8'd1));
        vecs.push_back(mk("unmap_idle",  0, 4'b0000, 4'hF,    4'h0,    1, 0, 32'h0, 0, 8'd1));
        vecs.push_back(mk("b2b_addr1",   1, 4'b0000, 4'hF,    4'h0,    1, 0, 32'h0, 0, 8'd1));
        vecs.push_back(mk("b2b_err1a",   1, 4'b0000, 4'hF,    4'h0,    0, 1, 32'h0, 0, 8'd2));
        vecs.push_back(mk("b2b_err2a",   1, 4'b0000, 4'hF,    4'h0,    1, 1, 32'h0, 0, 8'd2));
        vecs.push_back(mk("b2b_err1b",   1, 4'b0001, 4'hF,    4'h0,    0, 1, 32'h0, 0, 8'd3));
        vecs.push_back(mk("b2b_err2b",   1, 4'b0001, 4'hF,    4'h0,    1, 1, 32'h0, 0, 8'd3));
        vecs.push_back(mk("b2b_p0",      0, 4'b0000, 4'hF,    4'h0,    1, 0, D0,    0, 8'd3));
        vecs.push_back(mk("multi_addr",  1, 4'b0101, 4'hF,    4'h0,    1, 0, 32'h0, 0, 8'd3));
        vecs.push_back(mk("multi_data",  0, 4'b0000, 4'hF,    4'h0,    1, 0, D0,    1, 8'd3));
        vecs.push_back(mk("multi_gone",  0, 4'b0000, 4'hF,    4'h0,    1, 0, 32'h0, 0, 8'd3));
        vecs.push_back(mk("multi_idle",  0, 4'b0101, 4'hF,    4'h0,    1, 0, 32'h0, 0, 8'd3));
        vecs.push_back(mk("multi_ichk",  0, 4'b0000, 4'hF,    4'h0,    1, 0, 32'h0, 0, 8'd3));
        vecs.push_back(mk("p2_addr",     1, 4'b0100, 4'hF,    4'h0,    1, 0, 32'h0, 0, 8'd3));
        vecs.push_back(mk("p2_err_a",    0, 4'b0000, 4'b1011, 4'b0100, 0, 1, D2,    0, 8'd3));
        vecs.push_back(mk("p2_err_b",    0, 4'b0000, 4'hF,    4'b0100, 1, 1, D2,    0, 8'd3));
        vecs.push_back(mk("end_idle",    0, 4'b0000, 4'hF,    4'h0,    1, 0, 32'h0, 0, 8'd3));

        // Reset state.
        do_reset();
        #1;
        check("reset.hreadyout", 32'(hreadyout_a), 32'd1);
        check("reset.hresp",     32'(hresp_a),     32'd0);
        check("reset.hrdata",    hrdata_a,         32'h0);
        check("reset.multi_sel", 32'(multi_a),     32'd0);
        check("reset.err_cnt",   32'(cnt_a),       32'd0);

        // Table-driven main sequence through the scoreboard.
        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            @(negedge HCLK);
            apply(vecs[i].trans, vecs[i].hsel, vecs[i].rdy, vecs[i].resp);
            exp_q.push_back('{vecs[i].name, vecs[i].e_rdy, vecs[i].e_resp,
                              vecs[i].e_data, vecs[i].e_multi, vecs[i].e_cnt});
            #1;
            e = exp_q.pop_front();
            check({e.name, ".hreadyout"}, 32'(hreadyout_a), 32'(e.e_rdy));
            check({e.name, ".hresp"},     32'(hresp_a),     32'(e.e_resp));
            check({e.name, ".hrdata"},    hrdata_a,         e.e_data);
            check({e.name, ".multi_sel"}, 32'(multi_a),     32'(e.e_multi));
            check({e.name, ".err_cnt"},   32'(cnt_a),       32'(e.e_cnt));
        end
        check("scoreboard.empty", 32'(exp_q.size()), 32'd0);

        // Port 2 disabled on instance B: a P2 transfer gets the ERROR response
        // there while instance A serves it normally.
        do_reset();
        @(negedge HCLK);
        apply(1'b1, 4'b0100, 4'hF, 4'h0);
        #1;
        check_b("p2off_addr", 1'b1, 1'b0, 32'h0, 8'd0);
        @(negedge HCLK);
        apply(1'b0, 4'b0000, 4'hF, 4'h0);
        #1;
        check_a("p2on_data",  1'b1, 1'b0, D2,    8'd0);
        check_b("p2off_err1", 1'b0, 1'b1, 32'h0, 8'd1);
        @(negedge HCLK);
        #1;
        check_b("p2off_err2", 1'b1, 1'b1, 32'h0, 8'd1);
        @(negedge HCLK);
        #1;
        check_b("p2off_idle", 1'b1, 1'b0, 32'h0, 8'd1);

        // Reset asserted while in ERR1 wins on the next edge.
        do_reset();
        @(negedge HCLK);
        apply(1'b1, 4'b0000, 4'hF, 4'h0);
        #1;
        check_a("rst_err_addr", 1'b1, 1'b0, 32'h0, 8'd0);
        @(negedge HCLK);
        apply(1'b0, 4'b0000, 4'hF, 4'h0);
        #1;
        check_a("rst_err_err1", 1'b0, 1'b1, 32'h0, 8'd1);
        HRESETn = 1'b0;
        @(negedge HCLK);
        #1;
        check_a("rst_err_after", 1'b1, 1'b0, 32'h0, 8'd0);
        HRESETn = 1'b1;

        // Saturation: held unmapped NONSEQ gives one ERR1 entry every two
        // edges, so after k edges the count is (k+1)/2 until it sticks at 255.
        do_reset();
        @(negedge HCLK);
        apply(1'b1, 4'b0000, 4'hF, 4'h0);
        repeat (507) @(posedge HCLK);
        @(negedge HCLK);
        #1;
        check("sat.cnt_254", 32'(cnt_a), 32'd254);
        repeat (93) @(posedge HCLK);
        @(negedge HCLK);
        #1;
        check("sat.cnt_255", 32'(cnt_a), 32'd255);
        check("sat.multi",   32'(multi_a), 32'd0);
        apply(1'b0, 4'b0000, 4'hF, 4'h0);
        repeat (4) @(posedge HCLK);
        @(negedge HCLK);
        #1;
        check("sat.hold_255", 32'(cnt_a), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
